alarm_ctrl: RTL and testbench

Alarm supervisory state machine that sits directly upstream of the LCD status display. It samples zone sensors, an arm request and a keypad "code accepted" pulse, and runs the exit and entry delays. It drives the 2-bit message select consumed by the display stage, plus the siren and status outputs. It is the only producer of the display's message code.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_sync.sv | 23 ++
 rtl/alarm_ctrl.sv | 120 ++++++++++++
 tb/tb_alarm_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm supervisor and the LCD display stage:
// FSM state encoding and the message-select codes.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARMING,
    ST_ARMED,
    ST_LEVEL1,
    ST_LEVEL2
  } alarm_state_t;

  localparam logic [1:0] MESG_OFF  = 2'd0;
  localparam logic [1:0] MESG_SAFE = 2'd1;
  localparam logic [1:0] MESG_LVL1 = 2'd2;
  localparam logic [1:0] MESG_LVL2 = 2'd3;

  function automatic logic [1:0] mesg_of(input alarm_state_t s);
    case (s)
      ST_ARMED:  mesg_of = MESG_SAFE;
      ST_LEVEL1: mesg_of = MESG_LVL1;
      ST_LEVEL2: mesg_of = MESG_LVL2;
      default:   mesg_of = MESG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/alarm_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-high reset.
module alarm_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm supervisory FSM: exit/entry delays, zone latching, siren and display message select.
// Define ALARM_SIREN_PULSE_EN to make the siren toggle once per tick in LEVEL2.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned EXIT_TICKS  = 30,
  parameter int unsigned ENTRY_TICKS = 15,
  parameter int unsigned N_ZONES     = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iARM,
  input  logic               iCODE_OK,
  input  logic [N_ZONES-1:0] iSENSOR,
  output logic [1:0]         oMESG,
  output logic               oSIREN,
  output logic               oARMED,
  output logic [N_ZONES-1:0] oZONE
);

  localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_TICKS = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
  localparam int unsigned TCNT_W    = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;

  alarm_state_t       state, state_nxt;
  logic [N_ZONES-1:0] zone_nxt;
  logic [N_ZONES-1:0] sensor_s;
  logic               arm_s, arm_d, arm_edge;
  logic [PRE_W-1:0]   presc;
  logic [TCNT_W-1:0]  tcnt;
  logic               timed, tick;

  alarm_sync #(.WIDTH(N_ZONES)) u_sensor_sync (
    .clk (iCLK),
    .rst (iRST),
    .d   (iSENSOR),
    .q   (sensor_s)
  );

  alarm_sync #(.WIDTH(1)) u_arm_sync (
    .clk (iCLK),
    .rst (iRST),
    .d   (iARM),
    .q   (arm_s)
  );

  // The rise is registered, so an arm request costs one cycle more than a sensor trip.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      arm_d    <= 1'b0;
      arm_edge <= 1'b0;
    end else begin
      arm_d    <= arm_s;
      arm_edge <= arm_s & ~arm_d;
    end
  end

  always_comb begin
    timed = (state == ST_ARMING) || (state == ST_LEVEL1) || (state == ST_LEVEL2);
    tick  = timed && (presc == PRE_W'(TICK_DIV - 1));
  end

  always_comb begin
    state_nxt = state;
    zone_nxt  = oZONE;
    case (state)
      ST_OFF:    if (arm_edge && (sensor_s == '0)) state_nxt = ST_ARMING;
      ST_ARMING: if (tick && (tcnt == TCNT_W'(EXIT_TICKS - 1))) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (|sensor_s) begin
          state_nxt = ST_LEVEL1;
          zone_nxt  = sensor_s;
        end
      end
      ST_LEVEL1: if (tick && (tcnt == TCNT_W'(ENTRY_TICKS - 1))) state_nxt = ST_LEVEL2;
      ST_LEVEL2: state_nxt = ST_LEVEL2;
      default:   state_nxt = ST_OFF;
    endcase
    // A valid code overrides any trip or delay expiry in the same cycle.
    if (iCODE_OK && (state != ST_OFF)) begin
      state_nxt = ST_OFF;
      zone_nxt  = '0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= ST_OFF;
      presc  <= '0;
      tcnt   <= '0;
      oMESG  <= MESG_OFF;
      oARMED <= 1'b0;
      oSIREN <= 1'b0;
      oZONE  <= '0;
    end else begin
      state  <= state_nxt;
      oZONE  <= zone_nxt;
      oMESG  <= mesg_of(state_nxt);
      oARMED <= (state_nxt != ST_OFF);

      if (state_nxt != state) begin
        presc <= '0;
        tcnt  <= '0;
      end else if (timed) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        if (tick && (state != ST_LEVEL2)) tcnt <= tcnt + TCNT_W'(1);
      end

`ifdef ALARM_SIREN_PULSE_EN
      if (state_nxt != ST_LEVEL2)  oSIREN <= 1'b0;
      else if (state != ST_LEVEL2) oSIREN <= 1'b1;
      else if (tick)               oSIREN <= ~oSIREN;
`else
      oSIREN <= (state_nxt == ST_LEVEL2);
`endif
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl with TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=2, N_ZONES=4.
module tb_alarm_ctrl;

  typedef struct packed {
    logic [1:0] mesg;
    logic       armed;
    logic       siren;
    logic [3:0] zone;
  } obs_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iARM = 1'b0;
  logic       iCODE_OK = 1'b0;
  logic [3:0] iSENSOR = '0;
  logic [1:0] oMESG;
  logic       oSIREN, oARMED;
  logic [3:0] oZONE;

  obs_t obs;
  obs_t e;
  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  assign obs = {oMESG, oARMED, oSIREN, oZONE};

  always #5 iCLK = ~iCLK;

  alarm_ctrl #(
    .TICK_DIV    (4),
    .EXIT_TICKS  (3),
    .ENTRY_TICKS (2),
    .N_ZONES     (4)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iARM     (iARM),
    .iCODE_OK (iCODE_OK),
    .iSENSOR  (iSENSOR),
    .oMESG    (oMESG),
    .oSIREN   (oSIREN),
    .oARMED   (oARMED),
    .oZONE    (oZONE)
  );

  function automatic obs_t mk(input logic [1:0] m, input logic a, input logic s, input logic [3:0] z);
    mk = {m, a, s, z};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    step(3);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs, e); end
    iRST = 1'b0;
    step(1);
    iCODE_OK = 1'b1;
    step(1);
    iCODE_OK = 1'b0;
    step(2);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL code_ok_in_off: got %b want %b", obs, e); end
  endtask

  task automatic test_arm;
    iARM = 1'b1;
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b1, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b1, 1'b0, 4'b0000));
    sb.push_back(mk(2'd1, 1'b1, 1'b0, 4'b0000));
    step(3);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL arm_latency_early: got %b want %b", obs, e); end
    step(1);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL arming_entry: got %b want %b", obs, e); end
    step(11);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL exit_delay_early: got %b want %b", obs, e); end
    step(1);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL armed_entry: got %b want %b", obs, e); end
    iARM = 1'b0;
  endtask

  task automatic test_trip_escalate_reset;
    iSENSOR = 4'b0100;
    sb.push_back(mk(2'd1, 1'b1, 1'b0, 4'b0000));
    sb.push_back(mk(2'd2, 1'b1, 1'b0, 4'b0100));
    sb.push_back(mk(2'd2, 1'b1, 1'b0, 4'b0100));
    sb.push_back(mk(2'd3, 1'b1, 1'b1, 4'b0100));
`ifdef ALARM_SIREN_PULSE_EN
    sb.push_back(mk(2'd3, 1'b1, 1'b0, 4'b0100));
`else
    sb.push_back(mk(2'd3, 1'b1, 1'b1, 4'b0100));
`endif
    sb.push_back(mk(2'd3, 1'b1, 1'b1, 4'b0100));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    step(2);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL trip_latency_early: got %b want %b", obs, e); end
    step(1);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL level1_entry: got %b want %b", obs, e); end
    iSENSOR = 4'b0011;
    step(7);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL entry_delay_early: got %b want %b", obs, e); end
    step(1);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL level2_entry: got %b want %b", obs, e); end
    step(4);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL siren_tick1: got %b want %b", obs, e); end
    step(4);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL siren_tick2: got %b want %b", obs, e); end
    step(2);
    iRST = 1'b1;
    #1;
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, e); end
    iSENSOR = 4'b0000;
    step(2);
    iRST = 1'b0;
    step(20);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL no_resume_after_reset: got %b want %b", obs, e); end
  endtask

  task automatic test_priority;
    iARM = 1'b1;
    sb.push_back(mk(2'd1, 1'b1, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    step(16);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL rearm_armed: got %b want %b", obs, e); end
    iARM = 1'b0;
    iSENSOR = 4'b0001;
    step(2);
    iCODE_OK = 1'b1;
    step(1);
    iCODE_OK = 1'b0;
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL code_beats_trip: got %b want %b", obs, e); end
    step(3);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL stays_off_after_code: got %b want %b", obs, e); end
  endtask

  task automatic test_blocked_arm;
    iSENSOR = 4'b0001;
    step(4);
    iARM = 1'b1;
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b1, 1'b0, 4'b0000));
    sb.push_back(mk(2'd0, 1'b0, 1'b0, 4'b0000));
    step(6);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL blocked_arm: got %b want %b", obs, e); end
    iSENSOR = 4'b0000;
    step(6);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL no_late_arm: got %b want %b", obs, e); end
    iARM = 1'b0;
    step(4);
    iARM = 1'b1;
    step(4);
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL new_edge_arms: got %b want %b", obs, e); end
    iCODE_OK = 1'b1;
    step(1);
    iCODE_OK = 1'b0;
    e = sb.pop_front(); n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL code_in_arming: got %b want %b", obs, e); end
    iARM = 1'b0;
  endtask

  initial begin
    test_reset;
    test_arm;
    test_trip_escalate_reset;
    test_priority;
    test_blocked_arm;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
